// File: rtl/plru_way_alloc.sv
// Per-set way allocator: valid tracking, tree pseudo-LRU replacement and a
// one-deep allocation response with deferred whole-set flush.
module plru_way_alloc #(
  parameter int unsigned NumWays = 8,
  localparam int unsigned LogWays = $clog2(NumWays)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               hit_valid_i,
  input  logic [LogWays-1:0] hit_way_i,
  input  logic [NumWays-1:0] lock_i,
  input  logic               alloc_valid_i,
  output logic               alloc_ready_o,
  output logic               alloc_rsp_valid_o,
  output logic [LogWays-1:0] alloc_rsp_way_o,
  output logic               alloc_rsp_evict_o,
  input  logic               alloc_rsp_ready_i,
  output logic [NumWays-1:0] valid_o
);

  typedef enum logic [1:0] {IDLE, RESP, FLUSH} state_e;

  state_e               state_q, state_d;
  logic [NumWays-1:0]   valid_q, valid_d;
  logic [NumWays-2:0]   tree_q, tree_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [LogWays-1:0]   rsp_way_q, rsp_way_d;
  logic                 rsp_evict_q, rsp_evict_d;

  logic                 inv_found;
  logic [LogWays-1:0]   inv_way, unl_way, plru_way, victim_way;
  logic                 victim_evict;
  logic                 accept;

  // Each node on the way's path is pointed away from it.
  function automatic logic [NumWays-2:0] touch(input logic [NumWays-2:0] t,
                                               input logic [LogWays-1:0] w);
    logic [NumWays-2:0] r;
    logic [LogWays-1:0] node;
    logic               b;
    r    = t;
    node = '0;
    for (int l = 0; l < int'(LogWays); l++) begin
      b       = w[LogWays-1-l];
      r[node] = ~b;
      node    = LogWays'(2 * node + 1 + b);
    end
    return r;
  endfunction

  function automatic logic [LogWays-1:0] plru(input logic [NumWays-2:0] t);
    logic [LogWays-1:0] w;
    logic [LogWays-1:0] node;
    logic               b;
    w    = '0;
    node = '0;
    for (int l = 0; l < int'(LogWays); l++) begin
      b               = t[node];
      w[LogWays-1-l]  = b;
      node            = LogWays'(2 * node + 1 + b);
    end
    return w;
  endfunction

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    unl_way   = '0;
    for (int i = int'(NumWays) - 1; i >= 0; i--) begin
      if (!valid_q[i] && !lock_i[i]) begin
        inv_found = 1'b1;
        inv_way   = LogWays'(i);
      end
      if (!lock_i[i]) unl_way = LogWays'(i);
    end
    plru_way = plru(tree_q);
    if (inv_found) begin
      victim_way   = inv_way;
      victim_evict = 1'b0;
    end else if (!lock_i[plru_way]) begin
      victim_way   = plru_way;
      victim_evict = 1'b1;
    end else begin
      victim_way   = unl_way;
      victim_evict = 1'b1;
    end
  end

  assign alloc_ready_o = (state_q == IDLE) && !flush_pend_q && !flush_i && |(~lock_i);
  assign accept        = alloc_valid_i && alloc_ready_o;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tree_d       = tree_q;
    flush_pend_d = flush_pend_q;
    rsp_way_d    = rsp_way_q;
    rsp_evict_d  = rsp_evict_q;

    // Hit touch first so the allocation touch wins on shared nodes.
    if (hit_valid_i && state_q != FLUSH) tree_d = touch(tree_d, hit_way_i);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_way_d           = victim_way;
          rsp_evict_d         = victim_evict;
          valid_d[victim_way] = 1'b1;
          tree_d              = touch(tree_d, victim_way);
          state_d             = RESP;
        end else if (flush_i) begin
          state_d = FLUSH;
        end
      end
      RESP: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (alloc_rsp_ready_i) state_d = (flush_pend_q || flush_i) ? FLUSH : IDLE;
      end
      FLUSH: begin
        valid_d      = '0;
        tree_d       = '0;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      tree_q       <= '0;
      flush_pend_q <= 1'b0;
      rsp_way_q    <= '0;
      rsp_evict_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tree_q       <= tree_d;
      flush_pend_q <= flush_pend_d;
      rsp_way_q    <= rsp_way_d;
      rsp_evict_q  <= rsp_evict_d;
    end
  end

  assign alloc_rsp_valid_o = (state_q == RESP);
  assign alloc_rsp_way_o   = rsp_way_q;
  assign alloc_rsp_evict_o = rsp_evict_q;
  assign valid_o           = valid_q;

`ifndef COMMON_CELLS_ASSERTS_OFF
  a_pow2: assert property (@(posedge clk_i) (NumWays & (NumWays - 1)) == 0);

  a_rsp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    alloc_rsp_valid_o && !alloc_rsp_ready_i |=>
      alloc_rsp_valid_o && $stable(alloc_rsp_way_o) && $stable(alloc_rsp_evict_o));

  a_not_locked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    accept |-> !lock_i[victim_way]);
`endif

endmodule

// File: tb/tb_plru_way_alloc.sv
// Directed bench for plru_way_alloc with 8 ways and hand-computed expectations.
module tb_plru_way_alloc;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       hit_valid_i;
  logic [2:0] hit_way_i;
  logic [7:0] lock_i;
  logic       alloc_valid_i;
  logic       alloc_ready_o;
  logic       alloc_rsp_valid_o;
  logic [2:0] alloc_rsp_way_o;
  logic       alloc_rsp_evict_o;
  logic       alloc_rsp_ready_i;
  logic [7:0] valid_o;

  int errors = 0;
  int checks = 0;

  plru_way_alloc #(.NumWays(8)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .hit_valid_i       (hit_valid_i),
    .hit_way_i         (hit_way_i),
    .lock_i            (lock_i),
    .alloc_valid_i     (alloc_valid_i),
    .alloc_ready_o     (alloc_ready_o),
    .alloc_rsp_valid_o (alloc_rsp_valid_o),
    .alloc_rsp_way_o   (alloc_rsp_way_o),
    .alloc_rsp_evict_o (alloc_rsp_evict_o),
    .alloc_rsp_ready_i (alloc_rsp_ready_i),
    .valid_o           (valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni            = 1'b0;
    flush_i           = 1'b0;
    hit_valid_i       = 1'b0;
    hit_way_i         = 3'd0;
    lock_i            = 8'h00;
    alloc_valid_i     = 1'b0;
    alloc_rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rsp_valid", 32'(alloc_rsp_valid_o), 32'd0);
    chk("rst_rsp_way", 32'(alloc_rsp_way_o), 32'd0);
    chk("rst_rsp_evict", 32'(alloc_rsp_evict_o), 32'd0);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(alloc_ready_o), 32'd1);
    rst_ni = 1'b1;
  endtask

  // One request with immediate consumption: response at t+1, back in IDLE at t+2.
  task automatic alloc(input string tag, input int w, input logic ev);
    alloc_valid_i     = 1'b1;
    alloc_rsp_ready_i = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(alloc_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    alloc_valid_i = 1'b0;
    chk({tag, "_rsp_valid"}, 32'(alloc_rsp_valid_o), 32'd1);
    chk({tag, "_way"}, 32'(alloc_rsp_way_o), 32'(w));
    chk({tag, "_evict"}, 32'(alloc_rsp_evict_o), 32'(ev));
    chk({tag, "_busy"}, 32'(alloc_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    alloc_rsp_ready_i = 1'b0;
    chk({tag, "_done"}, 32'(alloc_rsp_valid_o), 32'd0);
  endtask

  task automatic hit(input int w);
    chk("hit_on_valid_way", 32'(valid_o[w]), 32'd1);
    hit_valid_i = 1'b1;
    hit_way_i   = 3'(w);
    @(posedge clk_i);
    #1;
    hit_valid_i = 1'b0;
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) alloc($sformatf("fill%0d", i), i, 1'b0);
    chk("fill_valid_o", 32'(valid_o), 32'hFF);
  endtask

  initial begin
    do_reset();

    // Fill in order; tree then points back at way 0.
    fill8();
    alloc("ninth", 0, 1'b1);

    // Hit way 0 turns the root and its left subtree away: PLRU is way 4.
    hit(0);
    alloc("after_hit", 4, 1'b1);

    // Same with way 4 locked: lowest unlocked way 0 instead.
    do_reset();
    fill8();
    hit(0);
    lock_i = 8'h10;
    alloc("locked_plru", 0, 1'b1);
    lock_i = 8'h00;

    // Held response with flush and lock change mid-hold; tree still points at way 4.
    alloc_valid_i     = 1'b1;
    alloc_rsp_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    alloc_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      flush_i = (c == 1);
      lock_i  = (c >= 2) ? 8'h10 : 8'h00;
      chk($sformatf("hold%0d_valid", c), 32'(alloc_rsp_valid_o), 32'd1);
      chk($sformatf("hold%0d_way", c), 32'(alloc_rsp_way_o), 32'd4);
      chk($sformatf("hold%0d_evict", c), 32'(alloc_rsp_evict_o), 32'd1);
      @(posedge clk_i);
      #1;
    end
    flush_i           = 1'b0;
    lock_i            = 8'h00;
    chk("hold_end_way", 32'(alloc_rsp_way_o), 32'd4);
    alloc_rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    alloc_rsp_ready_i = 1'b0;
    chk("flush_state_rsp", 32'(alloc_rsp_valid_o), 32'd0);
    chk("flush_state_ready", 32'(alloc_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    chk("flushed_valid_o", 32'(valid_o), 32'd0);
    chk("flushed_ready", 32'(alloc_ready_o), 32'd1);
    alloc("post_flush", 0, 1'b0);

    // All locked: never ready; unlock way 3 only.
    do_reset();
    lock_i        = 8'hFF;
    alloc_valid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("all_locked%0d_ready", c), 32'(alloc_ready_o), 32'd0);
      @(posedge clk_i);
      #1;
      chk($sformatf("all_locked%0d_rsp", c), 32'(alloc_rsp_valid_o), 32'd0);
    end
    lock_i = 8'hF7;
    #1;
    chk("unlock3_ready", 32'(alloc_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    alloc_valid_i = 1'b0;
    chk("unlock3_way", 32'(alloc_rsp_way_o), 32'd3);
    chk("unlock3_evict", 32'(alloc_rsp_evict_o), 32'd0);
    chk("unlock3_valid_o", 32'(valid_o), 32'h08);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_rsp", 32'(alloc_rsp_valid_o), 32'd0);
    chk("async_rst_valid_o", 32'(valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
